// File: rtl/watchdog_pkg.sv
// Shared types and field positions for the watchdog output path.
package watchdog_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} stream_state_t;

  localparam int OB_MODE_HI = 7;
  localparam int OB_MODE_LO = 5;
  localparam int OB_MARK    = 4;
  localparam int OB_NIB_HI  = 3;
  localparam int NIB_W      = 4;

  // Counter width helper: never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/output_streamer.sv
// Captures an NWORDS x W frame plus mode tag and streams it as tagged nibble
// bytes over a valid/ready port, MSB nibble of word 0 first.
module output_streamer
  import watchdog_pkg::*;
#(
  parameter int W      = 32,
  parameter int NWORDS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        mode,
  input  logic [NWORDS*W-1:0] words,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [7:0]        out_byte,
  output logic              busy,
  output logic              done
);

  localparam int NIB   = W / NIB_W;
  localparam int BEATS = NWORDS * NIB;
  localparam int FW    = NWORDS * W;
  localparam int BW    = clog2_min1(BEATS);
  localparam int NW    = clog2_min1(NIB);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [NW-1:0] LAST_NIB  = NW'(NIB - 1);

  stream_state_t  state;
  logic [FW-1:0]  frame;
  logic [FW-1:0]  frame_in;
  logic [2:0]     cur_mode;
  logic [BW-1:0]  beat_cnt;
  logic [NW-1:0]  nib_cnt;
  logic           done_q;

  // Word 0 goes to the top of the shift register so it leaves first.
  always_comb begin
    frame_in = '0;
    for (int k = 0; k < NWORDS; k++)
      frame_in[(NWORDS-1-k)*W +: W] = words[k*W +: W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      frame    <= '0;
      cur_mode <= '0;
      beat_cnt <= '0;
      nib_cnt  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          frame    <= frame_in;
          cur_mode <= mode;
          beat_cnt <= '0;
          nib_cnt  <= '0;
          state    <= SEND;
        end
        SEND: if (abort) begin
          state <= IDLE;
        end else if (out_ready) begin
          frame    <= frame << NIB_W;
          beat_cnt <= beat_cnt + 1'b1;
          nib_cnt  <= (nib_cnt == LAST_NIB) ? '0 : nib_cnt + 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign done      = done_q;

  always_comb begin
    out_byte = '0;
    if (state == SEND) begin
      out_byte[OB_MODE_HI:OB_MODE_LO] = cur_mode;
      out_byte[OB_MARK]               = (nib_cnt == '0);
      out_byte[OB_NIB_HI:0]           = frame[FW-1 -: NIB_W];
    end
  end

endmodule

// File: tb/tb_output_streamer.sv
// Directed bench for output_streamer: default 32x2 instance plus an 8x1 instance.
module tb_output_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [2:0]  mode = '0;
  logic [63:0] words = '0;
  logic        out_valid, busy, done;
  logic [7:0]  out_byte;

  logic        start1 = 1'b0, abort1 = 1'b0, ready1 = 1'b0;
  logic [2:0]  mode1 = '0;
  logic [7:0]  words1 = '0;
  logic        valid1, busy1, done1;
  logic [7:0]  byte1;

  int vec = 0;
  int errs = 0;

  logic [7:0] EXP [16] = '{8'hB1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8,
                           8'hB9, 8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF, 8'hA0};

  always #5 clk = ~clk;

  output_streamer #(.W(32), .NWORDS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .words(words),
    .out_ready(out_ready), .out_valid(out_valid), .out_byte(out_byte), .busy(busy), .done(done)
  );

  output_streamer #(.W(8), .NWORDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .mode(mode1), .words(words1),
    .out_ready(ready1), .out_valid(valid1), .out_byte(byte1), .busy(busy1), .done(done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame();
    words     = {32'h9ABCDEF0, 32'h12345678};
    mode      = 3'b101;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vec++; if ({out_valid, busy, done} !== 3'b000) begin errs++; $display("FAIL reset_ctl got %b want 000", {out_valid, busy, done}); end
    vec++; if (out_byte !== 8'h00) begin errs++; $display("FAIL reset_byte got %h want 00", out_byte); end
    vec++; if ({valid1, busy1, done1, byte1} !== 11'd0) begin errs++; $display("FAIL reset_dut1 got %h want 0", {valid1, busy1, done1, byte1}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    load_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    words = 64'hFFFF_0000_FFFF_0000;
    mode  = 3'b010;
    for (int i = 0; i < 16; i++) begin
      vec++; if (out_valid !== 1'b1 || out_byte !== EXP[i] || done !== 1'b0) begin
        errs++; $display("FAIL basic_byte%0d got v=%b b=%h d=%b want v=1 b=%h d=0", i, out_valid, out_byte, done, EXP[i]);
      end
      tick();
    end
    vec++; if (done !== 1'b1 || busy !== 1'b0 || out_byte !== 8'h00) begin
      errs++; $display("FAIL basic_done got d=%b busy=%b b=%h want d=1 busy=0 b=00", done, busy, out_byte);
    end
    tick();
    vec++; if (done !== 1'b0) begin errs++; $display("FAIL basic_done_pulse got %b want 0", done); end
  endtask

  task automatic test_backpressure();
    int n = 0, dcnt = 0, cyc = 0;
    logic stalled = 1'b0;
    logic [7:0] held = '0;
    load_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 200 && !(dcnt > 0 && !busy)) begin
      if (done) dcnt++;
      if (busy) begin
        if (stalled && out_byte !== held) begin
          vec++; errs++; $display("FAIL bp_stable got %h want %h", out_byte, held);
        end
        out_ready = (cyc % 3 == 0);
        if (out_ready) begin
          vec++; if (n >= 16 || out_byte !== EXP[n[3:0]]) begin
            errs++; $display("FAIL bp_byte%0d got %h want %h", n, out_byte, EXP[n[3:0]]);
          end
          n++;
        end
        stalled = !out_ready;
        held    = out_byte;
      end
      cyc++;
      tick();
    end
    if (done) dcnt++;
    out_ready = 1'b1;
    vec++; if (n !== 16) begin errs++; $display("FAIL bp_count got %0d want 16", n); end
    vec++; if (dcnt !== 1) begin errs++; $display("FAIL bp_done_count got %0d want 1", dcnt); end
    tick();
  endtask

  task automatic test_start_busy();
    load_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vec++; if (out_byte !== EXP[i] || done !== 1'b0) begin
        errs++; $display("FAIL sb_byte%0d got %h d=%b want %h d=0", i, out_byte, done, EXP[i]);
      end
      start = (i == 5);
      if (i == 5) words = 64'h0123_4567_89AB_CDEF;
      tick();
    end
    start = 1'b0;
    vec++; if (done !== 1'b1) begin errs++; $display("FAIL sb_done got %b want 1", done); end
    tick();
    vec++; if (done !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL sb_single_done got d=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_abort();
    load_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 9; i++) begin
      vec++; if (out_byte !== EXP[i]) begin errs++; $display("FAIL ab_byte%0d got %h want %h", i, out_byte, EXP[i]); end
      abort = (i == 9);
      tick();
    end
    abort = 1'b0;
    vec++; if ({out_valid, busy, done} !== 3'b000 || out_byte !== 8'h00) begin
      errs++; $display("FAIL ab_idle got v/b/d=%b byte=%h want 000 00", {out_valid, busy, done}, out_byte);
    end
    tick();
    vec++; if (done !== 1'b0) begin errs++; $display("FAIL ab_no_done got %b want 0", done); end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vec++; if (out_valid !== 1'b1 || out_byte !== EXP[i]) begin
        errs++; $display("FAIL ab_refill%0d got %h want %h", i, out_byte, EXP[i]);
      end
      tick();
    end
    vec++; if (done !== 1'b1) begin errs++; $display("FAIL ab_refill_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_reset_mid();
    load_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 3; i++) begin
      vec++; if (out_byte !== EXP[i]) begin errs++; $display("FAIL rm_byte%0d got %h want %h", i, out_byte, EXP[i]); end
      rst = (i == 3);
      tick();
    end
    vec++; if ({out_valid, busy, done} !== 3'b000 || out_byte !== 8'h00) begin
      errs++; $display("FAIL rm_outputs got v/b/d=%b byte=%h want 000 00", {out_valid, busy, done}, out_byte);
    end
    rst = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vec++; if (out_byte !== EXP[i]) begin errs++; $display("FAIL rm_restart%0d got %h want %h", i, out_byte, EXP[i]); end
      tick();
    end
    vec++; if (done !== 1'b1) begin errs++; $display("FAIL rm_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_sweep();
    words1 = 8'hC3;
    mode1  = 3'b000;
    ready1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    vec++; if (valid1 !== 1'b1 || byte1 !== 8'h1C) begin errs++; $display("FAIL sw_byte0 got v=%b %h want v=1 1C", valid1, byte1); end
    tick();
    vec++; if (valid1 !== 1'b1 || byte1 !== 8'h03) begin errs++; $display("FAIL sw_byte1 got v=%b %h want v=1 03", valid1, byte1); end
    tick();
    vec++; if (done1 !== 1'b1 || busy1 !== 1'b0 || byte1 !== 8'h00) begin
      errs++; $display("FAIL sw_done got d=%b busy=%b b=%h want 1 0 00", done1, busy1, byte1);
    end
    tick();
    vec++; if (done1 !== 1'b0) begin errs++; $display("FAIL sw_done_pulse got %b want 0", done1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_busy();
    test_abort();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
